// File: rtl/mpu_sample_collect_if.sv
// Request/data handshake between the sample collector (master, the requester)
// and the shared I2C engine (slave).
interface mpu_sample_collect_if;
    logic       req;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] size;
    logic       gnt;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       done;
    logic       nack;

    modport master (output req, dev, reg_addr, size,
                    input  gnt, rd_valid, rd_data, done, nack);
    modport slave  (input  req, dev, reg_addr, size,
                    output gnt, rd_valid, rd_data, done, nack);
endinterface

// File: rtl/mpu_sample_collect.sv
// MPU sample collector: one I2C burst read per MPU_INT rising edge, committed atomically.
// Define SAMPLE_TIMESTAMP_EN to add a timestamp output captured at edge accept.
//
// state  | meaning
// IDLE   | waiting for a synchronised INT edge while en is high
// REQ    | holding i2c.req until grant; dropped if en falls
// RX     | collecting burst bytes into the shadow buffer, timeout armed
// COMMIT | shadow copied to sensor_data, sample_valid high
// ERR    | NACK, short read or timeout has been counted
module mpu_sample_collect #(
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter logic [7:0] START_REG   = 8'd59,
    parameter int         NBYTES      = 14,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mpu_int,
    mpu_sample_collect_if.master    i2c,
    output logic [8*NBYTES-1:0]     sensor_data,
    output logic                    sample_valid,
    output logic                    busy,
    output logic [15:0]             sample_cnt,
    output logic [7:0]              err_cnt,
    output logic [7:0]              ovr_cnt
`ifdef SAMPLE_TIMESTAMP_EN
    ,
    output logic [31:0]             timestamp
`endif
);

    localparam int             TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     NB8        = 8'(NBYTES);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RX, S_COMMIT, S_ERR} state_t;

    state_t              state, state_nxt;
    logic                int_s1, int_s2, int_d, int_edge;
    logic [7:0]          idx, idx_nxt;
    logic                take_byte;
    logic [TW-1:0]       timer;
    logic [8*NBYTES-1:0] shadow, shadow_nxt;
    logic                grant, commit_go, err_go;

    assign int_edge  = int_s2 & ~int_d;
    // Bytes beyond the burst length are dropped; idx saturates at NBYTES.
    assign take_byte = i2c.rd_valid && (idx < NB8);

    always_comb begin
        idx_nxt    = idx;
        shadow_nxt = shadow;
        if (take_byte) begin
            idx_nxt = idx + 8'd1;
            shadow_nxt[8*(NBYTES-1-int'(idx)) +: 8] = i2c.rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        commit_go = 1'b0;
        err_go    = 1'b0;
        case (state)
            S_IDLE: begin
                if (int_edge && en) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (i2c.gnt) begin
                    state_nxt = S_RX;
                    grant     = 1'b1;
                end else if (!en) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RX: begin
                // A byte arriving with DONE is counted before the length check.
                if (i2c.nack) begin
                    state_nxt = S_ERR;
                    err_go    = 1'b1;
                end else if (i2c.done) begin
                    if (idx_nxt == NB8) begin
                        state_nxt = S_COMMIT;
                        commit_go = 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                        err_go    = 1'b1;
                    end
                end else if (timer == '0) begin
                    state_nxt = S_ERR;
                    err_go    = 1'b1;
                end
            end
            S_COMMIT, S_ERR: state_nxt = S_IDLE;
            default:         state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        i2c.req      = (state == S_REQ);
        busy         = (state != S_IDLE);
        sample_valid = (state == S_COMMIT);
    end

    assign i2c.dev      = DEV_ADDR;
    assign i2c.reg_addr = START_REG;
    assign i2c.size     = NB8;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_s1      <= 1'b0;
            int_s2      <= 1'b0;
            int_d       <= 1'b0;
            idx         <= '0;
            timer       <= '0;
            shadow      <= '0;
            sensor_data <= '0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            ovr_cnt     <= '0;
        end else begin
            int_s1 <= mpu_int;
            int_s2 <= int_s1;
            int_d  <= int_s2;
            if (grant) begin
                idx   <= '0;
                timer <= TIMER_LOAD;
            end else if (state == S_RX) begin
                idx    <= idx_nxt;
                shadow <= shadow_nxt;
                if (timer != '0) timer <= timer - 1'b1;
            end
            // Commit on the DONE edge so sensor_data is already valid during the pulse.
            if (commit_go) begin
                sensor_data <= shadow_nxt;
                sample_cnt  <= sample_cnt + 16'd1;
            end
            if (err_go && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (int_edge && state != S_IDLE && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
        end
    end

`ifdef SAMPLE_TIMESTAMP_EN
    logic        accept;
    logic [31:0] ts_cnt, ts_cap;

    assign accept = (state == S_IDLE) && int_edge && en;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt    <= '0;
            ts_cap    <= '0;
            timestamp <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (accept)    ts_cap    <= ts_cnt;
            if (commit_go) timestamp <= ts_cap;
        end
    end
`endif

endmodule

// File: tb/tb_mpu_sample_collect.sv
// Bench for mpu_sample_collect: directed scenarios plus randomized bursts against a
// transaction-level model; outputs compared every cycle on the falling edge.
module tb_mpu_sample_collect;
    localparam int NB = 14;
    localparam int TO = 200;
    localparam logic [8*NB-1:0] T1_DATA = 112'h3B3C3D3E3F404142434445464748;
    localparam logic [8*NB-1:0] T3_DATA = 112'h101112131415161718191A1B1C1D;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, mpu_int = 1'b0;
    logic [8*NB-1:0] sensor_data;
    logic            sample_valid, busy;
    logic [15:0]     sample_cnt;
    logic [7:0]      err_cnt, ovr_cnt;
`ifdef SAMPLE_TIMESTAMP_EN
    logic [31:0]     timestamp;
`endif

    mpu_sample_collect_if i2c ();

    mpu_sample_collect #(
        .DEV_ADDR(7'h68), .START_REG(8'd59), .NBYTES(NB), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mpu_int(mpu_int), .i2c(i2c),
        .sensor_data(sensor_data), .sample_valid(sample_valid), .busy(busy),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .ovr_cnt(ovr_cnt)
`ifdef SAMPLE_TIMESTAMP_EN
        , .timestamp(timestamp)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin history, one in-flight transfer record and a byte queue.
    bit              h1, h2, h3, edge_s, was_busy;
    bit              m_active, m_granted, m_tail, m_tail_good;
    int              age;
    logic [7:0]      got[$];
    logic [8*NB-1:0] m_data;
    logic [15:0]     m_cnt;
    logic [7:0]      m_err, m_ovr;
    logic [31:0]     cyc, ts_cap, m_ts;

    function automatic void finish_xfer(input bit good);
        m_active    = 1'b0;
        m_tail      = 1'b1;
        m_tail_good = good;
        if (good) begin
            for (int i = 0; i < NB; i++) m_data[8*(NB-1-i) +: 8] = got[i];
            m_cnt = m_cnt + 16'd1;
            m_ts  = ts_cap;
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            {h1, h2, h3} = 3'b000;
            {m_active, m_granted, m_tail, m_tail_good} = 4'b0000;
            age = 0;
            got.delete();
            m_data = '0; m_cnt = '0; m_err = '0; m_ovr = '0;
            cyc = '0; ts_cap = '0; m_ts = '0;
        end else begin
            edge_s   = h2 && !h3;
            was_busy = m_active || m_tail;
            if (m_tail) begin
                m_tail = 1'b0;
            end else if (m_active && !m_granted) begin
                if (i2c.gnt) begin
                    m_granted = 1'b1;
                    got.delete();
                    age = 0;
                end else if (!en) begin
                    m_active = 1'b0;
                end
            end else if (m_active) begin
                if (i2c.rd_valid && got.size() < NB) got.push_back(i2c.rd_data);
                if (i2c.nack)           finish_xfer(1'b0);
                else if (i2c.done)      finish_xfer(got.size() == NB);
                else if (age == TO - 1) finish_xfer(1'b0);
                else                    age++;
            end else if (edge_s && en) begin
                m_active  = 1'b1;
                m_granted = 1'b0;
                ts_cap    = cyc;
            end
            if (edge_s && was_busy && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
            h3 = h2; h2 = h1; h1 = mpu_int;
            cyc = cyc + 32'd1;
        end
    end

    int  req_rises = 0, valid_pulses = 0;
    bit  prev_req = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("i2c_req",      i2c.req,      m_active && !m_granted);
            check("busy",         busy,         m_active || m_tail);
            check("sample_valid", sample_valid, m_tail && m_tail_good);
            check("sensor_data",  sensor_data,  m_data);
            check("sample_cnt",   sample_cnt,   m_cnt);
            check("err_cnt",      err_cnt,      m_err);
            check("ovr_cnt",      ovr_cnt,      m_ovr);
            check("i2c_dev",      i2c.dev,      7'h68);
            check("i2c_reg",      i2c.reg_addr, 8'd59);
            check("i2c_size",     i2c.size,     8'd14);
`ifdef SAMPLE_TIMESTAMP_EN
            check("timestamp",    timestamp,    m_ts);
`endif
            if (i2c.req && !prev_req) req_rises++;
            if (sample_valid) valid_pulses++;
            prev_req = i2c.req;
        end
    end

    task automatic pulse_int();
        mpu_int = 1'b1;
        repeat (2) @(negedge clk);
        mpu_int = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        for (int i = 0; i < 60; i++) begin
            if (i2c.req) break;
            @(negedge clk);
        end
        ok = i2c.req;
        check("req_seen", i2c.req, 1'b1);
    endtask

    task automatic do_grant(input int dly);
        repeat (dly) @(negedge clk);
        i2c.gnt = 1'b1;
        @(negedge clk);
        i2c.gnt = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int base, input bit rnd, input int gapmax,
                              input int ovr_at, input bit merge_done);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gapmax)) @(negedge clk);
            mpu_int      = (i == ovr_at);
            i2c.rd_valid = 1'b1;
            i2c.rd_data  = rnd ? 8'($urandom) : 8'(base + i);
            i2c.done     = merge_done && (i == n - 1);
            @(negedge clk);
            i2c.rd_valid = 1'b0;
            i2c.done     = 1'b0;
            i2c.rd_data  = 8'($urandom);
        end
        mpu_int = 1'b0;
    endtask

    task automatic pulse_done();
        i2c.done = 1'b1;
        @(negedge clk);
        i2c.done = 1'b0;
    endtask

    task automatic pulse_nack();
        i2c.nack = 1'b1;
        @(negedge clk);
        i2c.nack = 1'b0;
    endtask

    // Run until five quiet idle cycles; a stray pending request is dropped by lowering en.
    task automatic settle();
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 5; i++) begin
            if (i2c.req) begin
                en = 1'b0;
                quiet = 0;
            end else begin
                en = 1'b1;
                quiet = busy ? 0 : quiet + 1;
            end
            @(negedge clk);
        end
        en = 1'b1;
        check("settle_idle", busy, 1'b0);
    endtask

    bit ok;
    int n, kind, ovr, r0, v0, hi;
    bit mrg;

    initial begin
        i2c.gnt = 1'b0; i2c.rd_valid = 1'b0; i2c.rd_data = 8'h00;
        i2c.done = 1'b0; i2c.nack = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_data", sensor_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt",  sample_cnt, 16'd0);
        rst = 1'b0;
        en  = 1'b1;
        repeat (2) @(negedge clk);

        // Good 14-byte burst
        v0 = valid_pulses;
        pulse_int(); wait_req(ok);
        do_grant(2);
        send_bytes(NB, 59, 1'b0, 0, -1, 1'b0);
        pulse_done();
        repeat (3) @(negedge clk);
        check("t1_data",   sensor_data, T1_DATA);
        check("t1_cnt",    sample_cnt, 16'd1);
        check("t1_pulses", valid_pulses - v0, 1);

        // NACK after 5 bytes
        v0 = valid_pulses;
        pulse_int(); wait_req(ok);
        do_grant(0);
        send_bytes(5, 0, 1'b1, 0, -1, 1'b0);
        pulse_nack();
        @(negedge clk);
        check("t2_busy_low", busy, 1'b0);
        check("t2_err",    err_cnt, 8'd1);
        check("t2_data",   sensor_data, T1_DATA);
        check("t2_pulses", valid_pulses - v0, 0);

        // Short read, then an over-long read that commits only the first 14 bytes
        pulse_int(); wait_req(ok);
        do_grant(1);
        send_bytes(NB - 1, 0, 1'b1, 1, -1, 1'b0);
        pulse_done();
        settle();
        check("t3_err", err_cnt, 8'd2);
        pulse_int(); wait_req(ok);
        do_grant(0);
        send_bytes(NB + 2, 8'h10, 1'b0, 0, -1, 1'b1);
        settle();
        check("t3_data", sensor_data, T3_DATA);
        check("t3_cnt",  sample_cnt, 16'd2);

        // Second INT edge during the burst
        r0 = req_rises;
        pulse_int(); wait_req(ok);
        do_grant(0);
        send_bytes(NB, 8'h20, 1'b0, 0, 7, 1'b1);
        settle();
        check("t4_ovr",  ovr_cnt, 8'd1);
        check("t4_reqs", req_rises - r0, 1);
        check("t4_cnt",  sample_cnt, 16'd3);

        // EN low at the edge, then EN falling while requesting
        en = 1'b0;
        r0 = req_rises;
        pulse_int();
        repeat (8) @(negedge clk);
        check("t5_no_req", req_rises - r0, 0);
        en = 1'b1;
        pulse_int(); wait_req(ok);
        en = 1'b0;
        @(negedge clk);
        check("t5_req_drop", i2c.req, 1'b0);
        check("t5_err", err_cnt, 8'd2);
        en = 1'b1;
        settle();

        // Timeout: 200 RX cycles followed by the ERR cycle
        pulse_int(); wait_req(ok);
        do_grant(0);
        hi = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            hi++;
            @(negedge clk);
        end
        check("t6_busy_cycles", hi, TO + 1);
        check("t6_err", err_cnt, 8'd3);

        // Reset in the middle of RX, then stray strobes
        pulse_int(); wait_req(ok);
        do_grant(0);
        send_bytes(5, 0, 1'b1, 0, -1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_data", sensor_data, '0);
        check("rst_mid_cnt",  sample_cnt, 16'd0);
        check("rst_mid_err",  err_cnt, 8'd0);
        check("rst_mid_ovr",  ovr_cnt, 8'd0);
        check("rst_mid_busy", busy, 1'b0);
        v0 = valid_pulses;
        send_bytes(NB, 0, 1'b1, 0, -1, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_ignore_cnt",    sample_cnt, 16'd0);
        check("rst_ignore_pulses", valid_pulses - v0, 0);

        // Randomized bursts
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            en = 1'b1;
            if (kind == 9) begin
                en = 1'b0;
                pulse_int();
                repeat (6) @(negedge clk);
                en = 1'b1;
            end else begin
                pulse_int(); wait_req(ok);
                if (ok) begin
                    if (kind == 8) begin
                        en = 1'b0;
                        @(negedge clk);
                        en = 1'b1;
                    end else begin
                        do_grant($urandom_range(0, 4));
                        n   = (kind <= 5) ? $urandom_range(NB - 2, NB + 2) : $urandom_range(0, NB);
                        ovr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
                        mrg = (kind <= 5) && (n > 0) && ($urandom_range(0, 1) == 1);
                        send_bytes(n, 0, 1'b1, 2, ovr, mrg);
                        if (kind <= 5) begin
                            if (!mrg) pulse_done();
                        end else begin
                            pulse_nack();
                        end
                    end
                end
            end
            settle();
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
